// File: rtl/wb_pkg.sv
// Shared Wishbone encodings and the read-master state type.
package wb_pkg;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;
  localparam logic [1:0] BTE_LINEAR  = 2'b00;
  localparam logic [3:0] SEL_WORD    = 4'hF;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2
  } rd_state_e;

  function automatic logic [31:0] next_word_adr(input logic [31:0] adr);
    return adr + 32'd4;
  endfunction

endpackage

// File: rtl/wshb_if.sv
// Wishbone bus bundle, read-only subset used by the burst read master.
interface wshb_if;
  logic        cyc;
  logic        stb;
  logic        we;
  logic [3:0]  sel;
  logic [31:0] adr;
  logic [2:0]  cti;
  logic [1:0]  bte;
  logic [31:0] dat_sm;
  logic        ack;

  modport master (output cyc, stb, we, sel, adr, cti, bte, input dat_sm, ack);
  modport slave  (input cyc, stb, we, sel, adr, cti, bte, output dat_sm, ack);
endinterface

// File: rtl/wb_rd_fifo.sv
// Synchronous FIFO buffering read data; a push and a pop may share a cycle even when full.
module wb_rd_fifo #(
  parameter  int FIFO_DEPTH = 4,
  parameter  int DW         = 32,
  localparam int AW         = $clog2(FIFO_DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [DW-1:0] din,
  input  logic          pop,
  output logic [DW-1:0] dout,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count
);

  logic [DW-1:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          w_do_pop;
  logic          w_do_push;

  assign empty     = (r_count == '0);
  assign full      = (r_count == (AW+1)'(FIFO_DEPTH));
  assign count     = r_count;
  assign dout      = r_mem[r_rd_ptr];
  assign w_do_pop  = pop && !empty;
  // A pop in the same cycle frees the slot the push needs.
  assign w_do_push = push && (!full || w_do_pop);

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/wb_read_master.sv
// Wishbone incrementing-burst read master feeding a small ready/valid output buffer.
// state | meaning: IDLE wait for start | READ cyc held, beats issued | DRAIN wait for buffer empty
module wb_read_master
  import wb_pkg::*;
#(
  parameter int LEN_W      = 12,
  parameter int FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  wshb_if.master           wb_m,
  input  logic             start,
  input  logic [31:0]      base_adr,
  input  logic [LEN_W-1:0] n_words,
  output logic             busy,
  output logic             done,
  output logic [31:0]      out_data,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int               CNT_W   = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CNT_W-1:0] OCC_MAX = CNT_W'(FIFO_DEPTH - 1);

  rd_state_e        r_state;
  rd_state_e        w_state_nxt;
  logic [31:0]      r_adr;
  logic [LEN_W-1:0] r_remaining;
  logic             r_done_zero;

  logic             w_cyc;
  logic             w_stb;
  logic [3:0]       w_sel;
  logic [2:0]       w_cti;
  logic             w_beat;
  logic             w_last;
  logic             w_start_ok;
  logic             w_launch;
  logic             w_drain_done;
  logic             w_push;
  logic             w_pop;
  logic             w_full;
  logic             w_empty;
  logic [CNT_W-1:0] w_count;

  assign w_last       = (r_remaining == LEN_W'(1));
  assign w_start_ok   = (r_state == ST_IDLE) && start;
  assign w_launch     = w_start_ok && (n_words != '0);
  assign w_drain_done = (r_state == ST_DRAIN) && w_empty;
  assign w_beat       = w_stb && wb_m.ack;
  assign out_valid    = !w_empty;
  assign w_pop        = out_valid && out_ready;
  assign w_push       = w_beat && (!w_full || w_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cyc       = 1'b0;
    w_stb       = 1'b0;
    w_sel       = 4'h0;
    w_cti       = CTI_CLASSIC;
    case (r_state)
      ST_IDLE: begin
        if (w_launch) w_state_nxt = ST_READ;
      end
      ST_READ: begin
        w_cyc = 1'b1;
        w_sel = SEL_WORD;
        w_cti = w_last ? CTI_EOB : CTI_INCR;
        // Stall the bus (cyc kept) when the buffer has no free slot.
        w_stb = (w_count <= OCC_MAX);
        if (w_stb && wb_m.ack && w_last) w_state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (w_empty) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_adr       <= '0;
      r_remaining <= '0;
      r_done_zero <= 1'b0;
    end else begin
      r_done_zero <= w_start_ok && (n_words == '0);
      if (w_launch) begin
        r_adr       <= base_adr & ~32'h3;
        r_remaining <= n_words;
      end else if (w_beat) begin
        r_adr       <= next_word_adr(r_adr);
        r_remaining <= r_remaining - 1'b1;
      end
    end
  end

  wb_rd_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .DW         (32)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (w_push),
    .din   (wb_m.dat_sm),
    .pop   (w_pop),
    .dout  (out_data),
    .full  (w_full),
    .empty (w_empty),
    .count (w_count)
  );

  assign wb_m.cyc = w_cyc;
  assign wb_m.stb = w_stb;
  assign wb_m.we  = 1'b0;
  assign wb_m.sel = w_sel;
  assign wb_m.adr = r_adr;
  assign wb_m.cti = w_cti;
  assign wb_m.bte = BTE_LINEAR;

  assign busy = (r_state != ST_IDLE) && !w_drain_done;
  assign done = w_drain_done || r_done_zero;

endmodule

// File: doc/wb_read_master.md
WB_READ_MASTER -- requirements
Module: wb_read_master

Interface
REQ-001 SHALL have parameter LEN_W, default 12, width of the word-count field.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, output buffer depth in words (power of two, at least 2).
REQ-003 SHALL have port clk, input, 1, single clock shared with the Wishbone bus.
REQ-004 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port wb_m, wshb_if.master, -, Wishbone master bus: cyc, stb, we, sel, adr, cti, bte, dat_sm, ack.
REQ-006 SHALL have port start, input, 1, one-cycle pulse that launches a transfer; sampled only when busy=0.
REQ-007 SHALL have port base_adr, input, 32, byte address of the first word; bits [1:0] ignored, treated as 00.
REQ-008 SHALL have port n_words, input, LEN_W, number of 32-bit words to read; 0 means no bus activity.
REQ-009 SHALL have port busy, output, 1, high from the accepted start until the last word leaves the buffer.
REQ-010 SHALL have port done, output, 1, one-cycle pulse on the cycle busy falls.
REQ-011 SHALL have port out_data, output, 32, head word of the output buffer.
REQ-012 SHALL have port out_valid, output, 1, out_data is valid.
REQ-013 SHALL have port out_ready, input, 1, consumer accepts the word when out_valid and out_ready are both high.

Function
REQ-014 SHALL implement FSM IDLE -> READ -> DRAIN -> IDLE.
REQ-015 SHALL, in IDLE on start with n_words>0, latch the address and count and enter READ; with n_words=0, SHALL pulse done on the next cycle and stay in IDLE.
REQ-016 SHALL hold wb_m.cyc=1 throughout READ, with we=0, sel=4'hF and bte=2'b00.
REQ-017 SHALL, in READ, drive stb=1 only while buffer occupancy is at most FIFO_DEPTH-1; otherwise stb=0 and cyc remains 1.
REQ-018 SHALL keep adr and cti stable while stb=1 until ack is received.
REQ-019 SHALL drive cti=3'b010 (incrementing burst) on all beats except the last, and cti=3'b111 on the last beat.
REQ-020 SHALL, on each cycle with stb and ack both high, write dat_sm into the buffer, add 4 to adr (32-bit wrap) and decrement the remaining count.
REQ-021 SHALL tolerate an ack that arrives any number of cycles after stb rises, with no timeout.
REQ-022 SHALL, on the ack of the last beat, drop cyc and stb in the next cycle and enter DRAIN.
REQ-023 SHALL, in DRAIN, leave IDLE once the buffer is empty, clearing busy and pulsing done in the same cycle.
REQ-024 SHALL support a buffer push and pop in the same cycle, leaving occupancy unchanged, including when the buffer is full.
REQ-025 SHALL give 1-cycle latency from ack to out_valid.
REQ-026 SHALL ignore start while busy=1.

Reset
REQ-027 SHALL, while rst=1, asynchronously force: FSM=IDLE, cyc=0, stb=0, we=0, sel=0, adr=0, cti=0, bte=0, buffer empty, out_valid=0, busy=0, done=0.
REQ-028 SHALL, on reset during READ, abort the transfer, drop cyc immediately and discard the buffer contents.

Structure
REQ-029 SHALL take Wishbone cti encodings (CTI_CLASSIC=000, CTI_INCR=010, CTI_EOB=111) and the FSM state enum from a shared package, wb_pkg.
REQ-030 SHALL contain one sub-module, wb_rd_fifo: a synchronous FIFO with parameter FIFO_DEPTH, async reset, push/pop/full/empty/count ports.

Verification
REQ-031 SHALL cover: base=0x100, n=4, out_ready=1, with the wb_bram slave -> adr sequence 0x100, 0x104, 0x108, 0x10C; cti 010, 010, 010, 111; 4 words out in order; done pulses once.
REQ-032 SHALL cover: n=8, out_ready=0 -> stb drops after 4 acks with cyc held at 1; raising out_ready resumes the reads; all 8 words delivered with none lost.
REQ-033 SHALL cover: n=0 -> no cyc assertion; done pulses 1 cycle after start.
REQ-034 SHALL cover: base=0xFFFFFFFC, n=2 -> second address is 0x00000000.
REQ-035 SHALL cover: rst asserted after the 2nd ack of n=6 -> cyc=0 and out_valid=0 in the same cycle; a new start with n=3 afterwards completes normally.
REQ-036 SHALL cover: start pulsed while busy -> ignored; word count and addresses of the active transfer are unchanged.
